spi_slave_top: RTL and testbench
================================

SPI_SLAVE_TOP -- requirements
Module: spi_slave_top

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI pad input (minimum 2).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port wb_rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port wb_adr_i, input, 5 bits: register select on bits [4:2]; 0=RX, 1=TX, 2=CTRL, 3=STATUS.
REQ-005 SHALL have port wb_dat_i, input, 32 bits: write data. Port wb_dat_o, output, 32 bits: registered read data.
REQ-006 SHALL have port wb_sel_i, input, 4 bits: byte enables. Ports wb_we_i, wb_stb_i, wb_cyc_i, input, 1 bit each: standard Wishbone.
REQ-007 SHALL have outputs wb_ack_o, wb_err_o and wb_int_o, 1 bit each: acknowledge, error (tied 0) and interrupt.
REQ-008 SHALL have inputs ss_pad_i (active-low select), sclk_pad_i and mosi_pad_i, 1 bit each, all asynchronous to wb_clk_i.
REQ-009 SHALL have outputs miso_pad_o, 1 bit (serial out), and miso_padoen_o, 1 bit (active-low output enable, 0 only while selected and CTRL.en=1).

Function
REQ-010 SHALL acknowledge as wb_ack_o = cyc & stb & ~wb_ack_o, registered, giving one-cycle ack and back-to-back spacing of 2 cycles; register side effects occur on the ack cycle.
REQ-011 SHALL use CTRL layout: [4:0] char_len (0 means 32), [5] cpol, [6] cpha, [7] lsb, [8] ie, [9] en; unused bits read 0; byte-lane writes honour wb_sel_i.
REQ-012 SHALL ignore CTRL writes while STATUS.active=1.
REQ-013 SHALL use STATUS layout: [0] rx_full, [1] tx_empty, [2] overrun, [3] active, [4] underrun; writing 1 to bit 2 or bit 4 clears it; other bits are read-only.
REQ-014 SHALL pass sclk, ss and mosi through SYNC_STAGES flops, then detect edges in the wb_clk_i domain; the supported sclk is at most wb_clk_i/8.
REQ-015 SHALL define the leading edge as sclk leaving cpol; cpha=0 samples on the leading edge and drives on the trailing edge; cpha=1 drives on the leading edge and samples on the trailing edge.
REQ-016 SHALL implement FSM IDLE/LOAD/SHIFT: IDLE->LOAD on synced ss falling with en=1; LOAD lasts 1 cycle, then ->SHIFT; SHIFT->LOAD when a character completes and ss is still low; any state->IDLE on synced ss high or en=0.
REQ-017 In LOAD, SHALL copy TX into the shift register and set tx_empty=1; if tx_empty was already 1, SHALL load zeros and set underrun=1; with cpha=0 the first bit SHALL appear on miso_pad_o in LOAD.
REQ-018 SHALL shift MSB-first when lsb=0 and LSB-first when lsb=1, using only the low char_len bits.
REQ-019 SHALL complete a character when the bit counter reaches char_len; RX then receives the bits right-aligned with upper bits zero, and rx_full=1 within SYNC_STAGES+2 wb_clk_i cycles of the pad edge.
REQ-020 On completion with rx_full already 1, SHALL overwrite RX and set overrun=1.
REQ-021 On completion in the same cycle as an RX read ack, completion SHALL win: rx_full stays 1 with the new data and overrun is not set.
REQ-022 An RX read ack without completion SHALL clear rx_full.
REQ-023 A TX write SHALL overwrite TX and clear tx_empty; when a TX write coincides with LOAD, the old TX value is shifted and the new value is retained with tx_empty=0.
REQ-024 On ss deasserting mid-character, SHALL discard the partial character without changing rx_full or overrun and SHALL reset the bit counter.
REQ-025 SHALL drive wb_int_o as the registered level ie & (rx_full | overrun | underrun).

Reset
REQ-026 On wb_rst_ni=0 at a clock edge: wb_dat_o=0, wb_ack_o=0, wb_int_o=0, CTRL=0, RX=0, TX=0, rx_full=0, tx_empty=1, overrun=0, underrun=0, FSM=IDLE, bit counter=0, synchronizers loaded with idle values (ss=1, sclk=0, mosi=0), miso_pad_o=0, miso_padoen_o=1.
REQ-027 Reset asserted mid-character SHALL abort the character with no RX update.

Structure
REQ-028 Package spi_slave_defs SHALL hold register offsets, CTRL/STATUS bit positions, the FSM state encoding and the max character length (32).
REQ-029 Sub-module spi_slave_sync SHALL contain the per-pin synchronizer and rise/fall detect; it is instantiated 3 times.

Verification
REQ-030 cpol=0, cpha=0, len=8, MSB-first, TX=0xA5, master sends 0x3C -> MISO carries 0xA5; RX=0x3C; rx_full=1; tx_empty=1; wb_int_o=1 when ie=1.
REQ-031 cpol=1, cpha=1, len=0 (32), lsb=1, master sends 0xDEADBEEF -> RX=0xDEADBEEF; reading RX clears rx_full and drops wb_int_o.
REQ-032 Two 8-bit characters 0x11 then 0x22 with no RX read between them -> RX=0x22, overrun=1; writing 0x4 to STATUS clears overrun.
REQ-033 Character started with tx_empty=1 -> MISO all zeros, underrun=1.
REQ-034 ss rises after 5 of 8 bits, then a full 0x81 character follows -> RX=0x81, no overrun, only one rx_full event.
REQ-035 CTRL write while active -> CTRL unchanged; wb_rst_ni low mid-character -> all REQ-026 values on the next cycle.

Source files
------------

// File: rtl/spi_slave_defs_pkg.sv
// Shared definitions for the SPI slave: register map, CTRL/STATUS bit
// positions, FSM encoding and character-length helper.
package spi_slave_defs;

   localparam logic [2:0] REG_RX     = 3'd0;
   localparam logic [2:0] REG_TX     = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;

   localparam int CTRL_W    = 10;
   localparam int CTRL_CPOL = 5;
   localparam int CTRL_CPHA = 6;
   localparam int CTRL_LSB  = 7;
   localparam int CTRL_IE   = 8;
   localparam int CTRL_EN   = 9;

   localparam int STAT_RX_FULL  = 0;
   localparam int STAT_TX_EMPTY = 1;
   localparam int STAT_OVERRUN  = 2;
   localparam int STAT_ACTIVE   = 3;
   localparam int STAT_UNDERRUN = 4;

   localparam int MAX_CHAR_LEN = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } spi_state_e;

   // A char_len field of 0 encodes the maximum character length.
   function automatic logic [5:0] char_bits(input logic [4:0] len);
      return (len == 5'd0) ? 6'(MAX_CHAR_LEN) : {1'b0, len};
   endfunction

endpackage

// File: rtl/spi_slave_wb_if.sv
// Wishbone register-bus bundle for the SPI slave. A transfer is requested
// while cyc & stb are high and completes on the single cycle ack is high.
interface spi_slave_wb_if ();
   logic [4:0]  adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;
   logic        err;
   logic        irq;

   modport master (
      output adr, dat_w, sel, we, stb, cyc,
      input  dat_r, ack, err, irq
   );

   modport slave (
      input  adr, dat_w, sel, we, stb, cyc,
      output dat_r, ack, err, irq
   );
endinterface

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pad, with rise/fall
// pulses derived from the synchronized level.
module spi_slave_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pad_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pad_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_top.sv
// SPI slave with a Wishbone register interface: synchronizes the SPI pads
// into wb_clk_i, shifts characters of 1..32 bits in all four SPI modes.
module spi_slave_top
   import spi_slave_defs::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [4:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_int_o,
   input  logic        ss_pad_i,
   input  logic        sclk_pad_i,
   input  logic        mosi_pad_i,
   output logic        miso_pad_o,
   output logic        miso_padoen_o,
   output logic [1:0]  dbg_state_o
);

   logic ss_s, ss_rise, ss_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk_i(wb_clk_i), .rst_ni(wb_rst_ni), .pad_i(ss_pad_i),
      .level_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
   );
   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(wb_clk_i), .rst_ni(wb_rst_ni), .pad_i(sclk_pad_i),
      .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(wb_clk_i), .rst_ni(wb_rst_ni), .pad_i(mosi_pad_i),
      .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   spi_state_e        state_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [31:0]       rx_q, tx_q, tx_sr_q, rx_sr_q, dat_q;
   logic [5:0]        bit_cnt_q;
   logic              rx_full_q, tx_empty_q, overrun_q, underrun_q;
   logic              miso_q, padoen_q, ack_q, int_q;

   logic        cpol, cpha, lsb_first, ie, en;
   logic [4:0]  msb_idx;
   logic [5:0]  len_bits;
   logic        lead_edge, trail_edge, sample_edge, drive_edge, complete;
   logic        access, rd, wr, rx_read, tx_write, ctrl_write, status_write;
   logic [2:0]  reg_sel;
   logic [4:0]  status;
   logic [31:0] load_data_d, rx_shift_d, rd_data_d;
   logic        unused_ok;

   assign cpol      = ctrl_q[CTRL_CPOL];
   assign cpha      = ctrl_q[CTRL_CPHA];
   assign lsb_first = ctrl_q[CTRL_LSB];
   assign ie        = ctrl_q[CTRL_IE];
   assign en        = ctrl_q[CTRL_EN];
   assign msb_idx   = ctrl_q[4:0] - 5'd1;
   assign len_bits  = char_bits(ctrl_q[4:0]);

   // With cpha=0 the trailing edge that closes a character must not shift
   // the freshly loaded next character, hence the bit-counter guard.
   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign drive_edge  = cpha ? lead_edge : (trail_edge && bit_cnt_q != 6'd0);
   assign complete    = (state_q == S_SHIFT) && sample_edge && (bit_cnt_q + 6'd1 == len_bits);

   assign access       = wb_cyc_i & wb_stb_i & ~ack_q;
   assign rd           = access & ~wb_we_i;
   assign wr           = access & wb_we_i;
   assign reg_sel      = wb_adr_i[4:2];
   assign rx_read      = rd && (reg_sel == REG_RX);
   assign tx_write     = wr && (reg_sel == REG_TX);
   assign ctrl_write   = wr && (reg_sel == REG_CTRL) && (state_q == S_IDLE);
   assign status_write = wr && (reg_sel == REG_STATUS);

   assign status      = {underrun_q, state_q != S_IDLE, overrun_q, tx_empty_q, rx_full_q};
   assign load_data_d = tx_empty_q ? 32'd0 : tx_q;
   assign rx_shift_d  = lsb_first ? ((rx_sr_q >> 1) | ({31'd0, mosi_s} << msb_idx))
                                  : {rx_sr_q[30:0], mosi_s};

   function automatic logic out_bit(input logic [31:0] sr, input logic lsb, input logic [4:0] msb);
      return lsb ? sr[0] : sr[msb];
   endfunction

   function automatic logic [31:0] advance(input logic [31:0] sr, input logic lsb);
      return lsb ? (sr >> 1) : (sr << 1);
   endfunction

   always_comb begin
      rd_data_d = 32'd0;
      case (reg_sel)
         REG_RX:     rd_data_d = rx_q;
         REG_TX:     rd_data_d = tx_q;
         REG_CTRL:   rd_data_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
         REG_STATUS: rd_data_d = {27'd0, status};
         default:    rd_data_d = 32'd0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q    <= S_IDLE;
         ctrl_q     <= '0;
         rx_q       <= 32'd0;
         tx_q       <= 32'd0;
         tx_sr_q    <= 32'd0;
         rx_sr_q    <= 32'd0;
         dat_q      <= 32'd0;
         bit_cnt_q  <= 6'd0;
         rx_full_q  <= 1'b0;
         tx_empty_q <= 1'b1;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
         padoen_q   <= 1'b1;
         ack_q      <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         ack_q    <= access;
         int_q    <= ie & (rx_full_q | overrun_q | underrun_q);
         padoen_q <= ss_s | ~en;
         if (rd) dat_q <= rd_data_d;

         // Bus-side clears come first so that shift-side sets override them.
         if (rx_read) rx_full_q <= 1'b0;
         if (status_write && wb_sel_i[0]) begin
            if (wb_dat_i[STAT_OVERRUN])  overrun_q  <= 1'b0;
            if (wb_dat_i[STAT_UNDERRUN]) underrun_q <= 1'b0;
         end
         if (ctrl_write && wb_sel_i[0]) ctrl_q[7:0] <= wb_dat_i[7:0];
         if (ctrl_write && wb_sel_i[1]) ctrl_q[9:8] <= wb_dat_i[9:8];

         if (ss_s || !en) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 6'd0;
         end else begin
            case (state_q)
               S_IDLE: if (ss_fall) state_q <= S_LOAD;
               S_LOAD: begin
                  state_q    <= S_SHIFT;
                  bit_cnt_q  <= 6'd0;
                  rx_sr_q    <= 32'd0;
                  tx_empty_q <= 1'b1;
                  if (tx_empty_q) underrun_q <= 1'b1;
                  if (!cpha) begin
                     miso_q  <= out_bit(load_data_d, lsb_first, msb_idx);
                     tx_sr_q <= advance(load_data_d, lsb_first);
                  end else begin
                     tx_sr_q <= load_data_d;
                  end
               end
               S_SHIFT: begin
                  if (drive_edge) begin
                     miso_q  <= out_bit(tx_sr_q, lsb_first, msb_idx);
                     tx_sr_q <= advance(tx_sr_q, lsb_first);
                  end
                  if (complete) begin
                     state_q   <= S_LOAD;
                     bit_cnt_q <= 6'd0;
                     rx_q      <= rx_shift_d;
                     rx_full_q <= 1'b1;
                     if (rx_full_q && !rx_read) overrun_q <= 1'b1;
                  end else if (sample_edge) begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                     rx_sr_q   <= rx_shift_d;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end

         // A TX write landing on the LOAD cycle keeps the new value queued.
         if (tx_write) begin
            for (int i = 0; i < 4; i++) begin
               if (wb_sel_i[i]) tx_q[8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
            tx_empty_q <= 1'b0;
         end
      end
   end

   assign wb_dat_o      = dat_q;
   assign wb_ack_o      = ack_q;
   assign wb_err_o      = 1'b0;
   assign wb_int_o      = int_q;
   assign miso_pad_o    = miso_q;
   assign miso_padoen_o = padoen_q;
   assign dbg_state_o   = state_q;
   assign unused_ok     = ^{wb_adr_i[1:0], ss_rise, mosi_rise, mosi_fall, sclk_s};

endmodule

// File: tb/tb_spi_slave_top.sv
// Directed bench for spi_slave_top: a table of single-character frames in
// all SPI modes plus hand-written overrun, abort and reset sequences.
module tb_spi_slave_top;
   import spi_slave_defs::*;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ss, sclk, mosi;
   logic       miso, padoen;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   spi_slave_wb_if wb_bus ();

   spi_slave_top #(.SYNC_STAGES(2)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wb_adr_i(wb_bus.adr), .wb_dat_i(wb_bus.dat_w), .wb_dat_o(wb_bus.dat_r),
      .wb_sel_i(wb_bus.sel), .wb_we_i(wb_bus.we), .wb_stb_i(wb_bus.stb),
      .wb_cyc_i(wb_bus.cyc), .wb_ack_o(wb_bus.ack), .wb_err_o(wb_bus.err),
      .wb_int_o(wb_bus.irq),
      .ss_pad_i(ss), .sclk_pad_i(sclk), .mosi_pad_i(mosi),
      .miso_pad_o(miso), .miso_padoen_o(padoen), .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // bus driver
   task automatic wb_access(input logic we, input logic [2:0] rsel, input logic [31:0] wdata,
                            output logic [31:0] rdata);
      bit got = 0;
      rdata = 32'd0;
      @(negedge clk);
      wb_bus.adr = {rsel, 2'b00}; wb_bus.dat_w = wdata; wb_bus.sel = 4'hF;
      wb_bus.we = we; wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_bus.ack) begin
            got = 1;
            rdata = wb_bus.dat_r;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL wb_ack: got no ack within 8 cycles, required ack");
      end
      @(negedge clk);
      wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
   endtask

   task automatic wb_write(input logic [2:0] rsel, input logic [31:0] wdata);
      logic [31:0] dummy;
      wb_access(1'b1, rsel, wdata, dummy);
   endtask

   task automatic wb_read(input logic [2:0] rsel, output logic [31:0] rdata);
      wb_access(1'b0, rsel, 32'd0, rdata);
   endtask

   // SPI master driver
   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic ss_begin(input logic cpol);
      sclk = cpol; half(); ss = 1'b0; half();
   endtask

   task automatic ss_end();
      half(); ss = 1'b1; half(); half();
   endtask

   task automatic send_bits(input logic [31:0] data, input int len, input int nbits,
                            input logic cpol, input logic cpha, input logic lsb,
                            output logic [31:0] miso_word);
      miso_word = 32'd0;
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = lsb ? i : len - 1 - i;
         if (!cpha) begin
            mosi = data[b]; half(); sclk = ~cpol; miso_word[b] = miso; half(); sclk = cpol;
         end else begin
            sclk = ~cpol; mosi = data[b]; half(); sclk = cpol; miso_word[b] = miso; half();
         end
      end
   endtask

   typedef struct {
      logic        cpol, cpha, lsb, ie;
      logic [4:0]  len;
      logic [31:0] tx, mosi_data, exp_rx, exp_miso;
      logic        exp_int;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [31:0] rd, mw, mw2;
      int nbits;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  32'h0000_00A5, 32'h0000_003C, 32'h0000_003C, 32'h0000_00A5, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  32'hFFFF_FFF9, 32'h0000_0006, 32'h0000_0006, 32'h0000_0009, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 32'h0000_BEEF, 32'h0000_1234, 32'h0000_1234, 32'h0000_BEEF, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 32'hC000_0001, 32'hD555_5555, 32'h5555_5555, 32'h4000_0001, 1'b0};

      rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      wb_bus.adr = '0; wb_bus.dat_w = '0; wb_bus.sel = '0;
      wb_bus.we = 1'b0; wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dat_o", wb_bus.dat_r, 32'd0);
      check("rst_ack", {31'd0, wb_bus.ack}, 32'd0);
      check("rst_int", {31'd0, wb_bus.irq}, 32'd0);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_padoen", {31'd0, padoen}, 32'd1);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wb_read(REG_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
      wb_read(REG_STATUS, rd); check("rst_status", rd, 32'h02);
      wb_read(REG_RX, rd);     check("rst_rx", rd, 32'd0);

      // table-driven single-character frames
      for (int v = 0; v < 6; v++) begin
         nbits = (vecs[v].len == 5'd0) ? 32 : int'(vecs[v].len);
         wb_write(REG_CTRL, {22'd0, 1'b1, vecs[v].ie, vecs[v].lsb, vecs[v].cpha, vecs[v].cpol, vecs[v].len});
         wb_write(REG_TX, vecs[v].tx);
         ss_begin(vecs[v].cpol);
         send_bits(vecs[v].mosi_data, nbits, nbits, vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, mw);
         ss_end();
         check($sformatf("vec%0d_miso", v), mw, vecs[v].exp_miso);
         check($sformatf("vec%0d_int_set", v), {31'd0, wb_bus.irq}, {31'd0, vecs[v].exp_int});
         wb_read(REG_STATUS, rd);
         check($sformatf("vec%0d_status", v), rd, 32'h13);
         wb_write(REG_STATUS, 32'h10);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_int_rxfull", v), {31'd0, wb_bus.irq}, {31'd0, vecs[v].exp_int});
         wb_read(REG_RX, rd);
         check($sformatf("vec%0d_rx", v), rd, vecs[v].exp_rx);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_int_clr", v), {31'd0, wb_bus.irq}, 32'd0);
         wb_read(REG_STATUS, rd);
         check($sformatf("vec%0d_status_clr", v), rd, 32'h02);
      end

      // two characters in one frame: overrun, then underrun on the second
      wb_write(REG_CTRL, 32'h308);
      wb_write(REG_TX, 32'h5A);
      ss_begin(1'b0);
      send_bits(32'h11, 8, 8, 1'b0, 1'b0, 1'b0, mw);
      send_bits(32'h22, 8, 8, 1'b0, 1'b0, 1'b0, mw2);
      ss_end();
      check("ovr_miso1", mw, 32'h5A);
      check("ovr_miso2", mw2, 32'h00);
      wb_read(REG_STATUS, rd); check("ovr_status", rd, 32'h17);
      wb_write(REG_STATUS, 32'h4);
      wb_read(REG_STATUS, rd); check("ovr_w1c", rd, 32'h13);
      wb_read(REG_RX, rd);     check("ovr_rx", rd, 32'h22);
      wb_write(REG_STATUS, 32'h10);

      // aborted partial character followed by a full one
      wb_write(REG_TX, 32'h33);
      ss_begin(1'b0);
      check("abort_padoen", {31'd0, padoen}, 32'd0);
      check("abort_state", {30'd0, dbg_state}, {30'd0, S_SHIFT});
      send_bits(32'hFF, 8, 5, 1'b0, 1'b0, 1'b0, mw);
      ss_end();
      check("abort_padoen_idle", {31'd0, padoen}, 32'd1);
      wb_read(REG_STATUS, rd); check("abort_partial", rd & 32'h5, 32'h0);
      ss_begin(1'b0);
      send_bits(32'h81, 8, 8, 1'b0, 1'b0, 1'b0, mw);
      ss_end();
      wb_read(REG_STATUS, rd); check("abort_full", rd & 32'h5, 32'h1);
      wb_read(REG_RX, rd);     check("abort_rx", rd, 32'h81);
      wb_write(REG_STATUS, 32'h14);

      // CTRL locked while active, then reset mid-character
      wb_write(REG_TX, 32'h44);
      ss_begin(1'b0);
      send_bits(32'h99, 8, 8, 1'b0, 1'b0, 1'b0, mw);
      send_bits(32'hF0, 8, 3, 1'b0, 1'b0, 1'b0, mw);
      check("lock_int", {31'd0, wb_bus.irq}, 32'd1);
      wb_write(REG_CTRL, 32'h0);
      wb_read(REG_CTRL, rd); check("lock_ctrl", rd, 32'h308);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_dat_o", wb_bus.dat_r, 32'd0);
      check("mid_rst_ack", {31'd0, wb_bus.ack}, 32'd0);
      check("mid_rst_int", {31'd0, wb_bus.irq}, 32'd0);
      check("mid_rst_miso", {31'd0, miso}, 32'd0);
      check("mid_rst_padoen", {31'd0, padoen}, 32'd1);
      check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk); rst_n = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (4) @(negedge clk);
      wb_read(REG_CTRL, rd);   check("mid_rst_ctrl", rd, 32'd0);
      wb_read(REG_STATUS, rd); check("mid_rst_status", rd, 32'h02);
      wb_read(REG_RX, rd);     check("mid_rst_rx", rd, 32'd0);
      wb_read(REG_TX, rd);     check("mid_rst_tx", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
